// File: rtl/commit_trace_buffer_pkg.sv
// Entry layout shared by the commit trace buffer and its FIFO.
// COMMIT_TRACE_WDATA_EN selects whether register-write fields are stored.
package commit_trace_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int WNUM_W  = 5;
    localparam int WDATA_W = 32;

    localparam int TRACE_ENTRY_W_WDATA = PC_W + INSTR_W + 1 + WNUM_W + WDATA_W + 1;  // 103
    localparam int TRACE_ENTRY_W_BASE  = PC_W + INSTR_W + 1;                         // 65

`ifdef COMMIT_TRACE_WDATA_EN
    localparam int TRACE_ENTRY_W = TRACE_ENTRY_W_WDATA;
    localparam int LLBIT_OFF     = 0;
    localparam int WDATA_OFF     = 1;
    localparam int WNUM_OFF      = WDATA_OFF + WDATA_W;
    localparam int WEN_OFF       = WNUM_OFF + WNUM_W;
    localparam int INSTR_OFF     = WEN_OFF + 1;
    localparam int PC_OFF        = INSTR_OFF + INSTR_W;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               wen;
        logic [WNUM_W-1:0]  wnum;
        logic [WDATA_W-1:0] wdata;
        logic               llbit;
    } trace_entry_t;
`else
    localparam int TRACE_ENTRY_W = TRACE_ENTRY_W_BASE;
    localparam int LLBIT_OFF     = 0;
    localparam int INSTR_OFF     = 1;
    localparam int PC_OFF        = INSTR_OFF + INSTR_W;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               llbit;
    } trace_entry_t;
`endif

    localparam logic [PC_W-1:0]    TRACE_PC_RST    = '0;
    localparam logic [INSTR_W-1:0] TRACE_INSTR_RST = '0;
    localparam logic               TRACE_WEN_RST   = 1'b0;
    localparam logic [WNUM_W-1:0]  TRACE_WNUM_RST  = '0;
    localparam logic [WDATA_W-1:0] TRACE_WDATA_RST = '0;
    localparam logic               TRACE_LLBIT_RST = 1'b0;

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Commit-side and trace-side signal bundle of the commit trace buffer.
// master = pipeline/trace consumer side, slave = the buffer.
interface commit_trace_buffer_if;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] commit_instr;
    logic        commit_wreg;
    logic [4:0]  commit_wd;
    logic [31:0] commit_wdata;
    logic        commit_llbit_we;
    logic        commit_llbit_value;
    logic        stall_req;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [31:0] trace_instr;
    logic        trace_wen;
    logic [4:0]  trace_wnum;
    logic [31:0] trace_wdata;
    logic        trace_llbit;
    logic [63:0] commit_count;
    logic        overflow;

    modport master (
        output commit_valid, commit_pc, commit_instr, commit_wreg, commit_wd,
               commit_wdata, commit_llbit_we, commit_llbit_value, trace_ready,
        input  stall_req, trace_valid, trace_pc, trace_instr, trace_wen,
               trace_wnum, trace_wdata, trace_llbit, commit_count, overflow
    );

    modport slave (
        input  commit_valid, commit_pc, commit_instr, commit_wreg, commit_wd,
               commit_wdata, commit_llbit_we, commit_llbit_value, trace_ready,
        output stall_req, trace_valid, trace_pc, trace_instr, trace_wen,
               trace_wnum, trace_wdata, trace_llbit, commit_count, overflow
    );
endinterface

// File: rtl/commit_trace_buffer_fifo.sv
// Generic synchronous FIFO; head_dat is a combinational read of the head, zero when empty.
// Latency: push visible at head one cycle later. Backpressure: push while full only lands with a same-cycle pop.
// Push/pop accepted in a reset cycle are ignored.
module commit_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);
    assign rd_en = pop && !empty && !rst;
    assign wr_en = push && (!full || rd_en) && !rst;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_dat  = empty ? '0 : mem[rd_ptr];
    assign occupancy = count;
endmodule

// File: rtl/commit_trace_buffer.sv
// MEM/WB commit stream endpoint: queues retired instructions and drains them to the trace port.
// Latency: 1 cycle push-to-head. Backpressure: stall_req when free <= AF_SLACK; commits into a full, non-popping FIFO are dropped.
// COMMIT_TRACE_WDATA_EN stores and presents the register-write fields; otherwise they read as 0.
module commit_trace_buffer
    import commit_trace_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int AF_SLACK = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    commit_trace_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] SLACK_CNT = (AW+1)'(AF_SLACK);

    trace_entry_t push_entry;
    trace_entry_t head_entry;
    logic [AW:0]  occ;
    logic         full;
    logic         empty;
    logic         fifo_push;
    logic         fifo_pop;
    logic         ll_shadow;
    logic         ll_next;
    logic [63:0]  count_q;
    logic         overflow_q;

    assign fifo_pop  = !empty && bus.trace_ready;
    assign fifo_push = bus.commit_valid && (!full || fifo_pop);

    // Entries carry the LLbit as it stands after their own update.
    assign ll_next = (bus.commit_valid && bus.commit_llbit_we) ? bus.commit_llbit_value : ll_shadow;

    always_comb begin
        push_entry       = '0;
        push_entry.pc    = bus.commit_pc;
        push_entry.instr = bus.commit_instr;
        push_entry.llbit = ll_next;
`ifdef COMMIT_TRACE_WDATA_EN
        push_entry.wen   = bus.commit_wreg;
        push_entry.wnum  = bus.commit_wd;
        push_entry.wdata = bus.commit_wdata;
`endif
    end

    commit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TRACE_ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_dat  (push_entry),
        .pop       (fifo_pop),
        .head_dat  (head_entry),
        .full      (full),
        .empty     (empty),
        .occupancy (occ)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ll_shadow  <= TRACE_LLBIT_RST;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            ll_shadow <= ll_next;
            if (bus.commit_valid) begin
                count_q <= count_q + 64'd1;
                if (!fifo_push) overflow_q <= 1'b1;
            end
        end
    end

    assign bus.stall_req    = (DEPTH_CNT - occ) <= SLACK_CNT;
    assign bus.trace_valid  = !empty;
    assign bus.trace_pc     = head_entry.pc;
    assign bus.trace_instr  = head_entry.instr;
    assign bus.trace_llbit  = head_entry.llbit;
    assign bus.commit_count = count_q;
    assign bus.overflow     = overflow_q;

`ifdef COMMIT_TRACE_WDATA_EN
    assign bus.trace_wen   = head_entry.wen;
    assign bus.trace_wnum  = head_entry.wnum;
    assign bus.trace_wdata = head_entry.wdata;
`else
    logic unused_wdata_fields;
    assign unused_wdata_fields = ^{bus.commit_wreg, bus.commit_wd, bus.commit_wdata};
    assign bus.trace_wen   = TRACE_WEN_RST;
    assign bus.trace_wnum  = TRACE_WNUM_RST;
    assign bus.trace_wdata = TRACE_WDATA_RST;
`endif
endmodule
